// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle multiply/divide engine with HI/LO result
// registers, MTHI/MTLO write-back and a registered busy flag for PC stall.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;
  logic                sign_a;
  logic                sign_b;
  logic [CW-1:0]       cnt;
  logic [2*WIDTH-1:0]  acc;

  logic                in_signed;
  logic [WIDTH-1:0]    a_abs;
  logic [WIDTH-1:0]    b_abs;
  logic [WIDTH:0]      mul_sum;
  logic [2*WIDTH-1:0]  mul_next;
  logic [WIDTH:0]      div_shift;
  logic                div_ge;
  logic [WIDTH-1:0]    div_diff;
  logic [2*WIDTH-1:0]  div_next;
  logic                q_signed;
  logic [2*WIDTH-1:0]  neg_acc;
  logic [WIDTH-1:0]    neg_rem;
  logic [WIDTH-1:0]    neg_quo;
  logic [WIDTH-1:0]    neg_a;
  logic [WIDTH-1:0]    fix_hi;
  logic [WIDTH-1:0]    fix_lo;
  logic                fix_dz;

  // Operand magnitudes for the incoming request (signed ops fold to abs value)
  always_comb begin
    in_signed = ~op[0];
    a_abs     = opA;
    b_abs     = opB;
    if (in_signed && opA[WIDTH-1]) a_abs = -opA;
    if (in_signed && opB[WIDTH-1]) b_abs = -opB;
  end

  // One iteration step: shift-add multiply and restoring divide share acc
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_mag});
    div_diff  = div_shift[WIDTH-1:0] - b_mag;
    if (div_ge) div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
    else        div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Final sign correction and divide-by-zero substitution for the HI/LO write
  always_comb begin
    q_signed = ~op_q[0];
    neg_acc  = -acc;
    neg_quo  = -acc[WIDTH-1:0];
    neg_rem  = -acc[2*WIDTH-1:WIDTH];
    neg_a    = -a_mag;
    fix_dz   = 1'b0;
    fix_hi   = acc[2*WIDTH-1:WIDTH];
    fix_lo   = acc[WIDTH-1:0];
    if (!op_q[1]) begin
      if (q_signed && (sign_a ^ sign_b)) begin
        fix_hi = neg_acc[2*WIDTH-1:WIDTH];
        fix_lo = neg_acc[WIDTH-1:0];
      end
    end else if (b_mag == '0) begin
      fix_dz = 1'b1;
      fix_lo = '1;
      fix_hi = (q_signed && sign_a) ? neg_a : a_mag;
    end else begin
      if (q_signed && (sign_a ^ sign_b)) fix_lo = neg_quo;
      if (q_signed && sign_a)            fix_hi = neg_rem;
    end
  end

  // Control FSM with registered busy/done/div_zero and HI/LO ownership
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      op_q     <= 2'b00;
      a_mag    <= '0;
      b_mag    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start) begin
            op_q     <= op;
            a_mag    <= a_abs;
            b_mag    <= b_abs;
            sign_a   <= opA[WIDTH-1];
            sign_b   <= opB[WIDTH-1];
            cnt      <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            acc      <= op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= op_q[1] ? div_next : mul_next;
          if (cnt == LAST) state <= FIX;
          else             cnt   <= cnt + 1'b1;
        end
        FIX: begin
          hi       <= fix_hi;
          lo       <= fix_lo;
          div_zero <= fix_dz;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against
// an arithmetic reference model (native 64-bit multiply, divide, modulo).
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .opA      (opA),
    .opB      (opB),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference model: returns {div_zero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'd0: begin p = sa * sb; return {1'b0, p}; end
      2'd1: begin p = ua * ub; return {1'b0, p}; end
      2'd2: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
        q = ua / ub;
        r = ua % ub;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation and watch it for 34 edges past the start edge
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input int extra_start_at, input int wr_hi_at,
                                input bit wr_lo_with_start);
    logic [64:0] exp;
    logic [31:0] hi_pre;
    logic [31:0] hi_cap;
    logic [31:0] lo_cap;
    logic        dz_cap;
    int          busy_cnt;
    int          done_cnt;
    int          done_idx;
    exp    = model(o, a, b);
    hi_pre = hi;
    op     = o;
    opA    = a;
    opB    = b;
    start  = 1'b1;
    if (wr_lo_with_start) begin
      wr_lo = 1'b1;
      wdata = 32'h0000CAFE;
    end
    @(posedge clk); #1;
    start = 1'b0;
    wr_lo = 1'b0;
    check_output("busy_after_start", 64'(busy), 64'(1'b1));
    check_output("dz_cleared_by_start", 64'(div_zero), 64'(1'b0));
    if (wr_lo_with_start) check_output("mtlo_with_start", 64'(lo), 64'h0000CAFE);
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    done_idx = -1;
    hi_cap   = hi;
    lo_cap   = lo;
    dz_cap   = div_zero;
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx = i;
          hi_cap   = hi;
          lo_cap   = lo;
          dz_cap   = div_zero;
        end
      end
      if (wr_hi_at > 0 && i == wr_hi_at + 1) check_output("mthi_ignored_in_run", 64'(hi), 64'(hi_pre));
      if (i == extra_start_at) begin
        start = 1'b1;
        op    = ~o;
        opA   = ~a;
        opB   = 32'h3;
      end else begin
        start = 1'b0;
      end
      if (i == wr_hi_at) begin
        wr_hi = 1'b1;
        wdata = 32'hDEADBEEF;
      end else begin
        wr_hi = 1'b0;
      end
    end
    start = 1'b0;
    wr_hi = 1'b0;
    check_output("busy_cycles", 64'(busy_cnt), 64'd33);
    check_output("done_pulses", 64'(done_cnt), 64'd1);
    check_output("done_edge", 64'(done_idx), 64'd33);
    check_output("hi_result", 64'(hi_cap), 64'(exp[63:32]));
    check_output("lo_result", 64'(lo_cap), 64'(exp[31:0]));
    check_output("div_zero_flag", 64'(dz_cap), 64'(exp[64]));
  endtask

  // Directed sequence followed by randomized operations
  initial begin
    int          saw_done;
    int          leak;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    opA   = 32'h0;
    opB   = 32'h0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_done", 64'(done), 64'd0);
    check_output("reset_dz", 64'(div_zero), 64'd0);
    check_output("reset_hi", 64'(hi), 64'd0);
    check_output("reset_lo", 64'(lo), 64'd0);

    apply_stimulus(2'd0, 32'hFFFFFFFD, 32'h00000007, 0, 0, 1'b0);
    apply_stimulus(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0);
    apply_stimulus(2'd2, 32'hFFFFFFF9, 32'h00000002, 0, 0, 1'b0);
    apply_stimulus(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1'b0);
    apply_stimulus(2'd3, 32'd100, 32'h0, 0, 0, 1'b0);
    @(posedge clk); #1;
    check_output("dz_sticky", 64'(div_zero), 64'd1);
    apply_stimulus(2'd1, 32'd9, 32'd11, 0, 0, 1'b0);
    apply_stimulus(2'd2, 32'hFFFFFFFB, 32'h0, 0, 0, 1'b0);
    apply_stimulus(2'd1, 32'd12345, 32'd678, 5, 0, 1'b0);

    wr_hi = 1'b1;
    wdata = 32'h00001234;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    check_output("mthi_idle", 64'(hi), 64'h00001234);
    apply_stimulus(2'd3, 32'd1000, 32'd7, 0, 3, 1'b0);
    apply_stimulus(2'd2, 32'd1000, 32'hFFFFFFF9, 0, 0, 1'b1);

    op    = 2'd1;
    opA   = 32'hABCDEF01;
    opB   = 32'h12345678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_output("midrun_reset_busy", 64'(busy), 64'd0);
    check_output("midrun_reset_done", 64'(done), 64'd0);
    check_output("midrun_reset_hi", 64'(hi), 64'd0);
    check_output("midrun_reset_lo", 64'(lo), 64'd0);
    saw_done = 0;
    leak     = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) saw_done++;
      if (hi != 32'h0 || lo != 32'h0) leak++;
    end
    check_output("midrun_no_done", 64'(saw_done), 64'd0);
    check_output("midrun_no_partial", 64'(leak), 64'd0);
    apply_stimulus(2'd0, 32'h7FFFFFFF, 32'h80000000, 0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      apply_stimulus(ro, ra, rb, 0, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the execute stage, directly downstream of the register file. Consumes the two register read buses as operands and computes a 64-bit result over 33 cycles. The result is held in HI/LO registers. A busy signal stalls the PC while the unit runs. HI/LO are read back onto the writeback bus through `hi`/`lo`.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`. Only 32 is verified.

Ports:
- `clk`: input, 1 bit. Rising-edge clock.
- `reset`: input, 1 bit. Synchronous, active-high; clock `clk`.
- `start`: input, 1 bit. Request a new operation. Sampled only in IDLE.
- `op`: input, 2 bits. Operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `opA`: input, WIDTH. Multiplicand or dividend, from busA.
- `opB`: input, WIDTH. Multiplier or divisor, from busB.
- `wr_hi`: input, 1 bit. MTHI strobe.
- `wr_lo`: input, 1 bit. MTLO strobe.
- `wdata`: input, WIDTH. Data for MTHI/MTLO.
- `busy`: output, 1 bit. Operation in progress; drives the stall.
- `done`: output, 1 bit. One-cycle pulse when HI/LO are updated.
- `div_zero`: output, 1 bit. Last completed divide had divisor 0. Sticky until the next start.
- `hi`: output, WIDTH. HI register.
- `lo`: output, WIDTH. LO register.

## Operation

- States:
  - IDLE: accept `start` or `wr_hi`/`wr_lo`.
  - RUN: `WIDTH` iterations, one per cycle.
  - FIX: sign correction and HI/LO write.
- IDLE -> RUN on `start`, which does the following:
  - Latch `op`.
  - Latch abs(opA) and abs(opB); for unsigned ops, take them as-is.
  - Latch the sign of opA and the sign of opB.
  - Clear the iteration counter.
  - Clear `div_zero`.
- RUN -> FIX when the counter reaches WIDTH-1. The counter is 5 bits and does not wrap inside RUN.
- FIX -> IDLE unconditionally.
- Multiply: shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle.
  - Signed: negate the 64-bit magnitude if signA xor signB.
  - HI = upper half, LO = lower half.
- Divide: restoring division, one quotient bit per cycle.
  - LO = quotient, HI = remainder.
  - Signed quotient sign = signA xor signB.
  - Signed remainder sign = signA.
  - Results are truncated toward zero.
- Divide by zero: full latency still applies. In FIX: LO = all ones, HI = original opA, `div_zero` = 1.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No flag is raised.
- `start` while busy (RUN or FIX): ignored, not queued.
- `wr_hi`/`wr_lo`: applied only in IDLE; ignored in RUN and FIX.
  - If `wr_hi`/`wr_lo` and `start` occur in the same IDLE cycle, both take effect. The write lands now; the operation overwrites HI/LO later.
- `hi`/`lo` are directly registered outputs and change only in FIX, on an MT write, or on reset.

## Timing

- Reset values: state IDLE, `busy` 0, `done` 0, `div_zero` 0, `hi` 0, `lo` 0, counter 0.
- Reset at any point, including mid-RUN: all of the above on the next edge. No `done` pulse. No partial result reaches HI/LO.
- Start accepted at edge E0:
  - `busy` is high from after E0 until after E33.
  - Iterations run on E1..E32.
  - FIX on E33: HI/LO, `div_zero`, and a one-cycle `done` pulse visible after E33. `busy` is low in the same cycle.
- Total latency: 33 cycles from the start edge to valid HI/LO.
- The next `start` can be accepted on E34 (the first cycle with `busy` low).
- `busy` is registered, not combinational from `start`. Control must also stall in the start cycle by ORing `start` with `busy`.
- MT writes: HI/LO are updated one edge after the strobe.

## Test plan

- MULT: opA=0xFFFFFFFD (-3), opB=7 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, `done` pulses once, `busy` high exactly 33 cycles.
- MULTU: 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV: -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV: 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU: 100/0 -> lo=0xFFFFFFFF, hi=0x64, `div_zero`=1. A following MULTU start clears `div_zero`.
- Reset and ignored inputs: pulse `reset` at cycle 10 of RUN -> next cycle `busy`=0, hi=lo=0, no `done`.
  - Separately: a second `start` at cycle 5 of RUN -> ignored, with the first result unchanged.
  - Separately: `wr_hi` with wdata=0x1234 in IDLE -> hi=0x1234 next cycle; the same `wr_hi` during RUN -> hi unchanged.
